galaga_dl_loader: RTL and testbench

//  Sits between the HPS ioctl download stream and the galaga core's dn_addr/dn_data/dn_wr port.

---
 rtl/galaga_pkg.sv | 14 +
 rtl/galaga_dl_loader.sv | 142 ++++++++++++++
 tb/tb_galaga_dl_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/galaga_pkg.sv
// Shared types and constants for the galaga core wrapper.
package galaga_pkg;

  typedef enum logic [1:0] {
    DL_HOLD,
    DL_RUN,
    DL_LOAD
  } dl_state_t;

  localparam int GALAGA_ROM_SIZE = 'h10000;
  localparam int GALAGA_RST_HOLD = 255;
  localparam int GALAGA_DN_AW    = 17;

endpackage

// File: rtl/galaga_dl_loader.sv
// ROM download front end for the galaga core.
// Registers the ioctl byte stream onto dn_addr/dn_data/dn_wr, rejects
// out-of-range addresses, tracks byte count and a mod-256 checksum, and
// keeps the core in reset while loading, for a settle time afterwards,
// and for as long as no complete image is present.
//
// state   | meaning
// --------+-----------------------------------------------------------
// DL_HOLD | core held in reset; hold_cnt runs down, then RUN if image ok
// DL_RUN  | core running; core_reset follows ext_reset
// DL_LOAD | download window open; bytes forwarded, core held in reset
module galaga_dl_loader
  import galaga_pkg::*;
#(
  parameter int AW       = GALAGA_DN_AW,
  parameter int ROM_SIZE = GALAGA_ROM_SIZE,
  parameter int RST_HOLD = GALAGA_RST_HOLD
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ext_reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [AW-1:0] dn_addr,
  output logic [7:0]    dn_data,
  output logic          dn_wr,
  output logic          core_reset,
  output logic          rom_valid,
  output logic          dl_err,
  output logic [7:0]    dl_sum
);

  // count must be able to hold ROM_SIZE itself, not just ROM_SIZE-1
  localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam int CW = $clog2(ROM_SIZE + 1);

  localparam logic [24:0]   ADDR_LIM  = 25'(ROM_SIZE);
  localparam logic [CW-1:0] CNT_FULL  = CW'(ROM_SIZE);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  dl_state_t     state;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] count;
  logic          ovf;

  logic          fresh;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    sum_base;
  logic          ovf_base;
  logic          in_range;
  logic          image_ok;

  // A download that starts this cycle counts from a clean slate, so the
  // first byte of the window is accepted on the same edge LOAD is entered.
  assign fresh    = (state != DL_LOAD);
  assign cnt_base = fresh ? '0 : count;
  assign sum_base = fresh ? 8'h00 : dl_sum;
  assign ovf_base = fresh ? 1'b0 : ovf;
  assign cnt_inc  = (cnt_base == CNT_FULL) ? cnt_base : cnt_base + 1'b1;
  assign in_range = (ioctl_addr < ADDR_LIM);
  assign image_ok = (count == CNT_FULL) && !ovf;

  // Sequencer, download datapath and hold timer in one registered block.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= DL_HOLD;
      hold_cnt   <= HOLD_INIT;
      count      <= '0;
      ovf        <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= 8'h00;
      dn_wr      <= 1'b0;
      core_reset <= 1'b1;
      rom_valid  <= 1'b0;
      dl_err     <= 1'b0;
      dl_sum     <= 8'h00;
    end else begin
      dn_wr <= 1'b0;
      if (ioctl_download) begin
        state      <= DL_LOAD;
        core_reset <= 1'b1;
        count      <= cnt_base;
        dl_sum     <= sum_base;
        ovf        <= ovf_base;
        if (fresh) begin
          rom_valid <= 1'b0;
          dl_err    <= 1'b0;
        end
        if (ioctl_wr) begin
          if (in_range) begin
            dn_addr <= ioctl_addr[AW-1:0];
            dn_data <= ioctl_dout;
            dn_wr   <= 1'b1;
            count   <= cnt_inc;
            dl_sum  <= sum_base + ioctl_dout;
          end else begin
            ovf <= 1'b1;
          end
        end
      end else begin
        case (state)
          DL_LOAD: begin
            state      <= DL_HOLD;
            hold_cnt   <= HOLD_INIT;
            core_reset <= 1'b1;
            rom_valid  <= image_ok;
            dl_err     <= !image_ok;
          end
          DL_RUN: begin
            if (ext_reset) begin
              state      <= DL_HOLD;
              hold_cnt   <= HOLD_INIT;
              core_reset <= 1'b1;
            end else begin
              core_reset <= 1'b0;
            end
          end
          DL_HOLD: begin
            if (hold_cnt != '0) begin
              hold_cnt   <= hold_cnt - 1'b1;
              core_reset <= 1'b1;
            end else if (rom_valid) begin
              state      <= DL_RUN;
              core_reset <= ext_reset;
            end else begin
              core_reset <= 1'b1;
            end
          end
          default: begin
            state      <= DL_HOLD;
            hold_cnt   <= HOLD_INIT;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_galaga_dl_loader.sv
// Directed/random bench for galaga_dl_loader with a cycle-level reference
// model expressed as download bookkeeping plus elapsed-cycle settle timing.
module tb_galaga_dl_loader;

  localparam int TB_AW   = 17;
  localparam int TB_ROM  = 1024;
  localparam int TB_HOLD = 255;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ext_reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [TB_AW-1:0]  dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              core_reset;
  logic              rom_valid;
  logic              dl_err;
  logic [7:0]        dl_sum;

  galaga_dl_loader #(
    .AW       (TB_AW),
    .ROM_SIZE (TB_ROM),
    .RST_HOLD (TB_HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ext_reset      (ext_reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .rom_valid      (rom_valid),
    .dl_err         (dl_err),
    .dl_sum         (dl_sum)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: what the outputs should be after the next rising edge
  logic             m_dn_wr;
  logic [TB_AW-1:0] m_dn_addr;
  logic [7:0]       m_dn_data;
  logic             m_core;
  logic             m_valid;
  logic             m_err;
  logic [7:0]       m_sum;
  int               m_cnt;
  logic             m_ovf;
  logic             m_loading;
  logic             m_running;
  int               m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("dn_wr",      32'(dn_wr),      32'(m_dn_wr));
    chk("dn_addr",    32'(dn_addr),    32'(m_dn_addr));
    chk("dn_data",    32'(dn_data),    32'(m_dn_data));
    chk("core_reset", 32'(core_reset), 32'(m_core));
    chk("rom_valid",  32'(rom_valid),  32'(m_valid));
    chk("dl_err",     32'(dl_err),     32'(m_err));
    chk("dl_sum",     32'(dl_sum),     32'(m_sum));
  endtask

  task automatic model_reset();
    m_dn_wr   = 1'b0;
    m_dn_addr = '0;
    m_dn_data = 8'h00;
    m_core    = 1'b1;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_sum     = 8'h00;
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_loading = 1'b0;
    m_running = 1'b0;
    m_since   = 0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_update();
    m_dn_wr = 1'b0;
    if (ioctl_download) begin
      if (!m_loading) begin
        m_loading = 1'b1;
        m_running = 1'b0;
        m_cnt     = 0;
        m_sum     = 8'h00;
        m_ovf     = 1'b0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
      end
      m_core = 1'b1;
      if (ioctl_wr) begin
        if (int'(ioctl_addr) < TB_ROM) begin
          m_dn_wr   = 1'b1;
          m_dn_addr = ioctl_addr[TB_AW-1:0];
          m_dn_data = ioctl_dout;
          m_sum     = m_sum + ioctl_dout;
          if (m_cnt < TB_ROM) m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else if (m_loading) begin
      m_loading = 1'b0;
      m_valid   = (m_cnt == TB_ROM) && !m_ovf;
      m_err     = !m_valid;
      m_since   = 0;
      m_core    = 1'b1;
    end else if (m_running) begin
      if (ext_reset) begin
        m_running = 1'b0;
        m_since   = 0;
        m_core    = 1'b1;
      end else begin
        m_core = 1'b0;
      end
    end else begin
      m_since++;
      if (m_since > TB_HOLD && m_valid) begin
        m_running = 1'b1;
        m_core    = ext_reset;
      end else begin
        m_core = 1'b1;
      end
    end
  endtask

  task automatic step(input logic dl, input logic wr, input logic [24:0] a,
                      input logic [7:0] d, input logic ext);
    @(negedge clk_sys);
    check_outputs();
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    ext_reset      = ext;
    model_update();
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk_sys);
    check_outputs();
    reset    = 1'b1;
    ioctl_wr = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (cyc) begin
      @(negedge clk_sys);
      check_outputs();
    end
    reset = 1'b0;
    model_update();
  endtask

  // Writes addresses first..first+n-1; fixed mode uses data=addr[7:0] and a
  // write every 4th cycle, otherwise random data, gaps and ext_reset noise.
  task automatic stream(input int first, input int n, input bit fixed);
    for (int i = 0; i < n; i++) begin
      int         a;
      int         gaps;
      logic [7:0] d;
      a    = first + i;
      d    = fixed ? a[7:0] : 8'($urandom);
      step(1'b1, 1'b1, 25'(a), d, fixed ? 1'b0 : 1'($urandom));
      gaps = fixed ? 3 : int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++)
        step(1'b1, 1'b0, 25'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  // Close the window with a stray write in the same cycle; it must be dropped.
  task automatic end_download();
    step(1'b0, 1'b1, 25'h0000_003, 8'hAA, 1'b0);
  endtask

  // Counts edges from the triggering edge until core_reset is seen low.
  task automatic hold_wait(output int n);
    n = 0;
    for (int k = 0; k < TB_HOLD + 40; k++) begin
      step(1'b0, 1'b0, 25'h0, 8'h00, 1'b0);
      if (core_reset === 1'b0) break;
      n++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'($urandom), 25'($urandom), 8'($urandom), 1'b0);
  endtask

  int n_hold;

  initial begin
    reset          = 1'b1;
    ext_reset      = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    model_reset();
    do_reset(2);

    // no image: core stays in reset, stray writes ignored
    idle(TB_HOLD + 100);
    chk("no_image_core_reset", 32'(core_reset), 32'd1);
    chk("no_image_rom_valid",  32'(rom_valid),  32'd0);

    // full image, data = addr[7:0], write every 4th cycle
    stream(0, TB_ROM, 1'b1);
    end_download();
    hold_wait(n_hold);
    chk("full_settle_cycles", 32'(n_hold),    32'(TB_HOLD + 1));
    chk("full_rom_valid",     32'(rom_valid), 32'd1);
    chk("full_dl_err",        32'(dl_err),    32'd0);
    chk("full_dl_sum",        32'(dl_sum),    32'h00);
    idle(20);

    // ext_reset pulse while running
    step(1'b0, 1'b0, 25'h0, 8'h00, 1'b1);
    hold_wait(n_hold);
    chk("ext_settle_cycles", 32'(n_hold),    32'(TB_HOLD + 1));
    chk("ext_rom_valid",     32'(rom_valid), 32'd1);
    idle(10);

    // short image, random data and gaps
    stream(0, TB_ROM - 1, 1'b0);
    end_download();
    idle(TB_HOLD + 30);
    chk("short_rom_valid",  32'(rom_valid),  32'd0);
    chk("short_dl_err",     32'(dl_err),     32'd1);
    chk("short_core_reset", 32'(core_reset), 32'd1);

    // full image followed by one out-of-range byte
    stream(0, TB_ROM, 1'b0);
    step(1'b1, 1'b1, 25'(TB_ROM), 8'h5A, 1'b0);
    step(1'b1, 1'b0, 25'h0, 8'h00, 1'b0);
    end_download();
    idle(TB_HOLD + 30);
    chk("ovf_rom_valid", 32'(rom_valid), 32'd0);
    chk("ovf_dl_err",    32'(dl_err),    32'd1);

    // reset halfway through a download; the tail forms a new, short load
    stream(0, TB_ROM / 2, 1'b0);
    do_reset(2);
    stream(TB_ROM / 2, TB_ROM / 2, 1'b0);
    end_download();
    idle(TB_HOLD + 30);
    chk("mid_reset_dl_err",    32'(dl_err),    32'd1);
    chk("mid_reset_rom_valid", 32'(rom_valid), 32'd0);

    // clean reload brings the core back out of reset
    stream(0, TB_ROM, 1'b0);
    end_download();
    hold_wait(n_hold);
    chk("reload_settle_cycles", 32'(n_hold),    32'(TB_HOLD + 1));
    chk("reload_rom_valid",     32'(rom_valid), 32'd1);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
